// File: rtl/rvs_pkg.sv
// Shared types and constants for the out-of-order reservation station.
package rvs_pkg;

    localparam int RVS_TAG_W = 5;
    localparam int RVS_OPC_W = 4;
    localparam int RVS_OFF_W = 12;
    localparam int RVS_DATA_W = 32;

    localparam logic [RVS_TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic                  valid;
        logic                  vld1;
        logic                  vld2;
        logic [RVS_TAG_W-1:0]  tag1;
        logic [RVS_TAG_W-1:0]  tag2;
        logic [RVS_DATA_W-1:0] src1;
        logic [RVS_DATA_W-1:0] src2;
        logic [RVS_OPC_W-1:0]  opc;
        logic [RVS_OFF_W-1:0]  offset;
    } rvs_entry_t;

endpackage

// File: rtl/rvs_age_mat.sv
// Age matrix: row i holds the slots that are older than slot i; grants the oldest requester.
module rvs_age_mat #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant
);

    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

    always_comb begin
        vld_d = vld_q;
        age_d = age_q;
        if (clear) begin
            vld_d = '0;
            age_d = '0;
        end else begin
            vld_d = (vld_q & ~free) | alloc;
            // A reused slot must not look older than anyone still holding a stale bit for it.
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc[j]) age_d[i][j] = 1'b0;
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc[i]) age_d[i] = vld_q & ~free;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] & ~|(age_q[i] & req);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            age_q <= '0;
        end else begin
            vld_q <= vld_d;
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/rvs_ooo.sv
// Out-of-order reservation station: CDB wakeup, oldest-ready issue, flush.
// Optional macro RVS_DISPATCH_BYPASS_EN captures a same-cycle CDB result at dispatch.
module rvs_ooo
    import rvs_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int TAG_W    = RVS_TAG_W,
    parameter int OPC_W    = RVS_OPC_W,
    parameter int START_ID = 1,
    parameter int CDB_N    = 2,
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  dec_req,
    output logic                  dec_rdy,
    input  logic [OPC_W-1:0]      dec_opc,
    input  logic [11:0]           dec_offset,
    input  logic                  dec_src1_vld,
    input  logic                  dec_src2_vld,
    input  logic [TAG_W-1:0]      dec_src1_tag,
    input  logic [TAG_W-1:0]      dec_src2_tag,
    input  logic [31:0]           dec_src1_wdata,
    input  logic [31:0]           dec_src2_wdata,
    output logic [TAG_W-1:0]      dec_tag,
    input  logic                  rob_busy,
    input  logic [CDB_N-1:0]      cdb_wr,
    input  logic [CDB_N*TAG_W-1:0] cdb_tag,
    input  logic [CDB_N*32-1:0]   cdb_wdata,
    output logic                  iss_req,
    input  logic                  iss_rdy,
    output logic [TAG_W-1:0]      iss_tag,
    output logic [OPC_W-1:0]      iss_opc,
    output logic [31:0]           iss_src1,
    output logic [31:0]           iss_src2,
    output logic [11:0]           iss_offset,
    output logic [PTR_W:0]        occupancy
);

    rvs_entry_t       ent_q [DEPTH];
    rvs_entry_t       ent_d [DEPTH];
    logic [PTR_W:0]   occ_q, occ_d;
    logic [DEPTH-1:0] valid_vec, ready_vec, grant, alloc_oh, free_oh;
    logic [PTR_W-1:0] free_idx, iss_idx;
    logic             full, dec_fire, iss_fire;
    logic             hit1, hit2;
    logic [31:0]      wk1, wk2;

    // Lowest-numbered CDB port wins when several broadcast the same tag.
    function automatic logic cdb_match(input logic [TAG_W-1:0] tag, output logic [31:0] data);
        logic hit;
        hit  = 1'b0;
        data = '0;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (cdb_wr[k] && tag != TAG_NONE && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
                hit  = 1'b1;
                data = cdb_wdata[k*32 +: 32];
            end
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            ready_vec[i] = ent_q[i].valid & ent_q[i].vld1 & ent_q[i].vld2;
        end
        full     = &valid_vec;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) free_idx = PTR_W'(i);
        end
    end

    rvs_age_mat #(.DEPTH(DEPTH)) u_age (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .alloc (alloc_oh),
        .free  (free_oh),
        .req   (ready_vec),
        .grant (grant)
    );

    always_comb begin
        iss_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) iss_idx = PTR_W'(i);
        end
        dec_rdy    = ~full & ~rob_busy & ~flush;
        dec_fire   = dec_req & dec_rdy;
        iss_req    = (|grant) & ~flush;
        iss_fire   = iss_req & iss_rdy;
        dec_tag    = TAG_W'(START_ID) + TAG_W'(free_idx);
        iss_tag    = TAG_W'(START_ID) + TAG_W'(iss_idx);
        iss_opc    = ent_q[iss_idx].opc;
        iss_src1   = ent_q[iss_idx].src1;
        iss_src2   = ent_q[iss_idx].src2;
        iss_offset = ent_q[iss_idx].offset;
        alloc_oh   = DEPTH'(dec_fire) << free_idx;
        free_oh    = iss_fire ? grant : '0;
        occupancy  = occ_q;
    end

    always_comb begin
        ent_d = ent_q;
        occ_d = occ_q;
        hit1  = 1'b0;
        hit2  = 1'b0;
        wk1   = '0;
        wk2   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = cdb_match(ent_q[i].tag1, wk1);
            hit2 = cdb_match(ent_q[i].tag2, wk2);
            if (ent_q[i].valid && !ent_q[i].vld1 && hit1) begin
                ent_d[i].vld1 = 1'b1;
                ent_d[i].src1 = wk1;
                ent_d[i].tag1 = TAG_NONE;
            end
            if (ent_q[i].valid && !ent_q[i].vld2 && hit2) begin
                ent_d[i].vld2 = 1'b1;
                ent_d[i].src2 = wk2;
                ent_d[i].tag2 = TAG_NONE;
            end
            if (free_oh[i]) ent_d[i].valid = 1'b0;
        end
        if (dec_fire) begin
            ent_d[free_idx].valid  = 1'b1;
            ent_d[free_idx].vld1   = dec_src1_vld;
            ent_d[free_idx].vld2   = dec_src2_vld;
            ent_d[free_idx].tag1   = dec_src1_vld ? TAG_NONE : dec_src1_tag;
            ent_d[free_idx].tag2   = dec_src2_vld ? TAG_NONE : dec_src2_tag;
            ent_d[free_idx].src1   = dec_src1_wdata;
            ent_d[free_idx].src2   = dec_src2_wdata;
            ent_d[free_idx].opc    = dec_opc;
            ent_d[free_idx].offset = dec_offset;
`ifdef RVS_DISPATCH_BYPASS_EN
            hit1 = cdb_match(dec_src1_tag, wk1);
            hit2 = cdb_match(dec_src2_tag, wk2);
            if (!dec_src1_vld && hit1) begin
                ent_d[free_idx].vld1 = 1'b1;
                ent_d[free_idx].src1 = wk1;
                ent_d[free_idx].tag1 = TAG_NONE;
            end
            if (!dec_src2_vld && hit2) begin
                ent_d[free_idx].vld2 = 1'b1;
                ent_d[free_idx].src2 = wk2;
                ent_d[free_idx].tag2 = TAG_NONE;
            end
`endif
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
            occ_d = '0;
        end else begin
            occ_d = occ_q + (PTR_W+1)'(dec_fire) - (PTR_W+1)'(iss_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            occ_q <= '0;
        end else begin
            ent_q <= ent_d;
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_rvs_ooo.sv
// Bench for rvs_ooo: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a slot/sequence-number model.
module tb_rvs_ooo;

    localparam int DEPTH = 8, TAG_W = 5, OPC_W = 4, START_ID = 1, CDB_N = 2, PTR_W = 3;

    logic                   clk, rst, flush, dec_req, dec_rdy;
    logic [OPC_W-1:0]       dec_opc;
    logic [11:0]            dec_offset;
    logic                   dec_src1_vld, dec_src2_vld;
    logic [TAG_W-1:0]       dec_src1_tag, dec_src2_tag, dec_tag;
    logic [31:0]            dec_src1_wdata, dec_src2_wdata;
    logic                   rob_busy;
    logic [CDB_N-1:0]       cdb_wr;
    logic [CDB_N*TAG_W-1:0] cdb_tag;
    logic [CDB_N*32-1:0]    cdb_wdata;
    logic                   iss_req, iss_rdy;
    logic [TAG_W-1:0]       iss_tag;
    logic [OPC_W-1:0]       iss_opc;
    logic [31:0]            iss_src1, iss_src2;
    logic [11:0]            iss_offset;
    logic [PTR_W:0]         occupancy;

    rvs_ooo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OPC_W(OPC_W), .START_ID(START_ID),
              .CDB_N(CDB_N), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .dec_req(dec_req), .dec_rdy(dec_rdy),
        .dec_opc(dec_opc), .dec_offset(dec_offset),
        .dec_src1_vld(dec_src1_vld), .dec_src2_vld(dec_src2_vld),
        .dec_src1_tag(dec_src1_tag), .dec_src2_tag(dec_src2_tag),
        .dec_src1_wdata(dec_src1_wdata), .dec_src2_wdata(dec_src2_wdata),
        .dec_tag(dec_tag), .rob_busy(rob_busy),
        .cdb_wr(cdb_wr), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
        .iss_req(iss_req), .iss_rdy(iss_rdy), .iss_tag(iss_tag), .iss_opc(iss_opc),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_offset(iss_offset),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a bag of slots, age expressed as a dispatch sequence number.
    bit               m_valid [DEPTH];
    int               m_seq   [DEPTH];
    bit               m_v1 [DEPTH], m_v2 [DEPTH];
    logic [TAG_W-1:0] m_t1 [DEPTH], m_t2 [DEPTH];
    logic [31:0]      m_s1 [DEPTH], m_s2 [DEPTH];
    logic [OPC_W-1:0] m_opc [DEPTH];
    logic [11:0]      m_off [DEPTH];
    int               seqcnt = 0;
    bit               live = 1'b0;

    function automatic bit m_cdb(input logic [TAG_W-1:0] t, output logic [31:0] d);
        d = '0;
        if (t == '0) return 1'b0;
        for (int k = 0; k < CDB_N; k++) begin
            if (cdb_wr[k] && cdb_tag[k*TAG_W +: TAG_W] == t) begin
                d = cdb_wdata[k*32 +: 32];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin : model
        int cnt, oldest, fs;
        bit exp_rdy, exp_iss, h;
        logic [31:0] d;
        cnt = 0; oldest = -1; fs = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i]) cnt++;
            else if (fs < 0) fs = i;
            if (m_valid[i] && m_v1[i] && m_v2[i] && (oldest < 0 || m_seq[i] < m_seq[oldest]))
                oldest = i;
        end
        exp_rdy = (cnt < DEPTH) && !rob_busy && !flush;
        exp_iss = (oldest >= 0) && !flush;
        if (live) begin
            chk("occupancy", 32'(occupancy), 32'(cnt));
            chk("dec_rdy", 32'(dec_rdy), 32'(exp_rdy));
            if (fs >= 0) chk("dec_tag", 32'(dec_tag), 32'(fs + START_ID));
            chk("iss_req", 32'(iss_req), 32'(exp_iss));
            if (exp_iss) begin
                chk("iss_tag", 32'(iss_tag), 32'(oldest + START_ID));
                chk("iss_opc", 32'(iss_opc), 32'(m_opc[oldest]));
                chk("iss_src1", iss_src1, m_s1[oldest]);
                chk("iss_src2", iss_src2, m_s2[oldest]);
                chk("iss_offset", 32'(iss_offset), 32'(m_off[oldest]));
            end
        end
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            live = 1'b1;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i] && !m_v1[i]) begin
                    h = m_cdb(m_t1[i], d);
                    if (h) begin m_v1[i] = 1'b1; m_s1[i] = d; end
                end
                if (m_valid[i] && !m_v2[i]) begin
                    h = m_cdb(m_t2[i], d);
                    if (h) begin m_v2[i] = 1'b1; m_s2[i] = d; end
                end
            end
            if (exp_iss && iss_rdy) m_valid[oldest] = 1'b0;
            if (dec_req && exp_rdy) begin
                m_valid[fs] = 1'b1;
                m_seq[fs]   = seqcnt++;
                m_v1[fs]    = dec_src1_vld;
                m_v2[fs]    = dec_src2_vld;
                m_t1[fs]    = dec_src1_tag;
                m_t2[fs]    = dec_src2_tag;
                m_s1[fs]    = dec_src1_wdata;
                m_s2[fs]    = dec_src2_wdata;
                m_opc[fs]   = dec_opc;
                m_off[fs]   = dec_offset;
`ifdef RVS_DISPATCH_BYPASS_EN
                if (!dec_src1_vld) begin
                    h = m_cdb(dec_src1_tag, d);
                    if (h) begin m_v1[fs] = 1'b1; m_s1[fs] = d; end
                end
                if (!dec_src2_vld) begin
                    h = m_cdb(dec_src2_tag, d);
                    if (h) begin m_v2[fs] = 1'b1; m_s2[fs] = d; end
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_req = 0; flush = 0; rob_busy = 0; cdb_wr = '0; cdb_tag = '0; cdb_wdata = '0;
        dec_opc = '0; dec_offset = '0; dec_src1_vld = 0; dec_src2_vld = 0;
        dec_src1_tag = '0; dec_src2_tag = '0; dec_src1_wdata = '0; dec_src2_wdata = '0;
    endtask

    task automatic disp(input logic [OPC_W-1:0] opc, input bit v1, input logic [TAG_W-1:0] t1,
                        input logic [31:0] d1, input bit v2, input logic [TAG_W-1:0] t2,
                        input logic [31:0] d2);
        idle();
        dec_req = 1; dec_opc = opc; dec_offset = 12'(opc) + 12'h100;
        dec_src1_vld = v1; dec_src1_tag = t1; dec_src1_wdata = d1;
        dec_src2_vld = v2; dec_src2_tag = t2; dec_src2_wdata = d2;
    endtask

    initial begin
        idle();
        rst = 1; iss_rdy = 0;
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_dec_rdy", 32'(dec_rdy), 1);
        chk("rst_dec_tag", 32'(dec_tag), 1);
        chk("rst_iss_req", 32'(iss_req), 0);

        // Three ready ops drain in dispatch order.
        for (int j = 0; j < 3; j++) begin
            disp(OPC_W'(j + 1), 1, 0, 32'(100 + j), 1, 0, 32'(200 + j));
            #1 chk("s1_dec_tag", 32'(dec_tag), 32'(j + 1));
            tick();
        end
        idle(); iss_rdy = 1;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("s1_iss_req", 32'(iss_req), 1);
            chk("s1_iss_tag", 32'(iss_tag), 32'(j + 1));
            chk("s1_iss_src1", iss_src1, 32'(100 + j));
            tick();
        end
        #1 chk("s1_empty", 32'(iss_req), 0);

        // Younger ready op bypasses a waiting older one; CDB port 1 wakes it.
        disp(4'd5, 0, 5'd9, 32'h0, 1, 0, 32'h2);
        #1 chk("s2_tagA", 32'(dec_tag), 1);
        tick();
        disp(4'd6, 1, 0, 32'h3, 1, 0, 32'h4);
        #1 chk("s2_tagB", 32'(dec_tag), 2);
        chk("s2_no_iss", 32'(iss_req), 0);
        tick();
        idle(); cdb_wr = 2'b10; cdb_tag = {5'd9, 5'd0}; cdb_wdata = {32'hDEADBEEF, 32'h0};
        #1 chk("s2_B_first", 32'(iss_tag), 2);
        tick();
        idle();
        #1 chk("s2_A_tag", 32'(iss_tag), 1);
        chk("s2_A_src1", iss_src1, 32'hDEADBEEF);
        tick();

        // Two ports broadcast the same tag: port 0 wins.
        disp(4'd7, 1, 0, 32'h3, 0, 5'd5, 32'h0);
        tick();
        idle(); cdb_wr = 2'b11; cdb_tag = {5'd5, 5'd5}; cdb_wdata = {32'h22, 32'h11};
        #1 chk("s3_wait", 32'(iss_req), 0);
        tick();
        idle();
        #1 chk("s3_src2", iss_src2, 32'h11);
        tick();

        // Fill, stall, free one slot.
        iss_rdy = 0;
        for (int j = 0; j < DEPTH; j++) begin
            disp(OPC_W'(j), 1, 0, 32'(j), 1, 0, 32'(j));
            #1 chk("s4_fill_tag", 32'(dec_tag), 32'(j + 1));
            tick();
        end
        idle();
        #1 chk("s4_full_rdy", 32'(dec_rdy), 0);
        chk("s4_full_occ", 32'(occupancy), 8);
        iss_rdy = 1;
        tick();
        iss_rdy = 0;
        #1 chk("s4_rdy_again", 32'(dec_rdy), 1);
        chk("s4_freed_tag", 32'(dec_tag), 1);
        chk("s4_occ7", 32'(occupancy), 7);

        // Flush with a concurrent dispatch.
        disp(4'd3, 1, 0, 32'h1, 1, 0, 32'h1);
        flush = 1;
        #1 chk("s5_iss_gated", 32'(iss_req), 0);
        chk("s5_dec_gated", 32'(dec_rdy), 0);
        tick();
        idle();
        #1 chk("s5_occ0", 32'(occupancy), 0);
        chk("s5_iss0", 32'(iss_req), 0);

        // Dispatch racing a broadcast of its pending tag.
        iss_rdy = 1;
        disp(4'd9, 1, 0, 32'h1, 0, 5'd7, 32'h0);
        cdb_wr = 2'b01; cdb_tag = {5'd0, 5'd7}; cdb_wdata = {32'h0, 32'h55};
        tick();
        idle();
`ifdef RVS_DISPATCH_BYPASS_EN
        #1 chk("s6_byp_iss", 32'(iss_req), 1);
        chk("s6_byp_src2", iss_src2, 32'h55);
        tick();
`else
        tick(); tick();
        chk("s6_stuck_iss", 32'(iss_req), 0);
        chk("s6_stuck_occ", 32'(occupancy), 1);
`endif
        flush = 1;
        tick();
        idle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            dec_req        = ($urandom_range(0, 9) < 7);
            dec_opc        = OPC_W'($urandom);
            dec_offset     = 12'($urandom);
            dec_src1_vld   = ($urandom_range(0, 1) == 1);
            dec_src2_vld   = ($urandom_range(0, 1) == 1);
            dec_src1_tag   = TAG_W'($urandom_range(0, 9));
            dec_src2_tag   = TAG_W'($urandom_range(0, 9));
            dec_src1_wdata = $urandom;
            dec_src2_wdata = $urandom;
            rob_busy       = ($urandom_range(0, 9) == 0);
            iss_rdy        = ($urandom_range(0, 9) < 7);
            flush          = ($urandom_range(0, 59) == 0);
            rst            = ($urandom_range(0, 299) == 0);
            cdb_wr         = CDB_N'($urandom);
            for (int k = 0; k < CDB_N; k++) begin
                cdb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 9));
                cdb_wdata[k*32 +: 32]     = $urandom;
            end
            tick();
        end
        idle(); rst = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
